// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-master round-robin arbiter in front of a single-port synchronous
//   memory. Port 0 is the core and port 1 is the loader/debug master. A
//   granted request is latched into the memory output registers. One access
//   is issued, and the ack and read data come back one cycle later.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   reqN, weN              request / write select for port N
//   addrN                  byte address (bits [1:0] ignored)
//   wdataN, wmaskN         write data and byte-lane enables
//   ackN, errN             one-cycle completion pulse; errN = out of range
//   rdataN                 read data, held until port N's next read completes
//   busy                   high while an access is in ISSUE or RESP
//   mem_en, mem_we         registered memory strobe / write enable
//   mem_addr, mem_wdata,   registered word address, write data, byte mask
//   mem_wmask
//   mem_rdata              memory read data, valid the cycle after mem_en
module mem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024,
  localparam int MW_A     = $clog2(MEM_WORDS),
  localparam int MASK_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [MASK_W-1:0] wmask0,
  input  logic [MASK_W-1:0] wmask1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MW_A-1:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_grant;
  logic              r_port;       // port owning the access in flight
  logic              r_we;
  logic              r_err_pend;
  logic [DATA_W-1:0] r_hold [2];
  logic              r_mem_en;
  logic              r_mem_we;
  logic [MW_A-1:0]   r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [MASK_W-1:0] r_mem_wmask;

  logic [1:0]        w_req_elig;
  logic              w_grant;
  logic              w_win;
  logic [31:0]       w_sel_addr;
  logic              w_sel_we;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [MASK_W-1:0] w_sel_wmask;
  logic              w_in_range;
  logic              w_capture;
  logic [DATA_W-1:0] w_resp_data;
  logic [1:0]        w_ack;
  logic [DATA_W-1:0] w_rdata [2];
  logic              w_unused;

  // Byte-offset bits never reach the word-addressed memory.
  assign w_unused = ^{addr0[1:0], addr1[1:0]};

  // Arbitration. The port being answered in RESP is masked so that the
  // other port can be granted in the same cycle. No grant is made in ISSUE.
  always_comb begin
    w_req_elig = {req1, req0};
    if (r_state == S_RESP) begin
      w_req_elig[r_port] = 1'b0;
    end
    w_grant = 1'b0;
    w_win   = 1'b0;
    if ((r_state != S_ISSUE) && (|w_req_elig)) begin
      w_grant = 1'b1;
      if (&w_req_elig) begin
        w_win = ~r_last_grant;
      end else begin
        w_win = w_req_elig[1];
      end
    end

    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_RESP;
      S_RESP:  w_state_next = w_grant ? S_ISSUE : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_sel_addr  = w_win ? addr1  : addr0;
  assign w_sel_we    = w_win ? we1    : we0;
  assign w_sel_wdata = w_win ? wdata1 : wdata0;
  assign w_sel_wmask = w_win ? wmask1 : wmask0;
  assign w_in_range  = ({2'b00, w_sel_addr[31:2]} < 32'(MEM_WORDS));

  // Reads and errors refresh the hold register; writes leave it alone.
  assign w_capture   = (r_state == S_RESP) && (!r_we || r_err_pend);
  assign w_resp_data = r_err_pend ? '0 : mem_rdata;

  // The memory registers are loaded at the grant edge, so the access is
  // already on the bus during ISSUE and the strobe falls again after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_err_pend   <= 1'b0;
      r_hold[0]    <= '0;
      r_hold[1]    <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      if (w_grant) begin
        r_last_grant <= w_win;
        r_port       <= w_win;
        r_we         <= w_sel_we;
        r_err_pend   <= ~w_in_range;
        r_mem_en     <= w_in_range;
        r_mem_we     <= w_in_range & w_sel_we;
        r_mem_addr   <= w_sel_addr[MW_A+1:2];
        r_mem_wdata  <= w_sel_wdata;
        r_mem_wmask  <= w_sel_wmask;
      end
      if (w_capture) begin
        r_hold[r_port] <= w_resp_data;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign w_ack[gi]   = (r_state == S_RESP) && (r_port == 1'(gi));
    assign w_rdata[gi] = (w_ack[gi] && w_capture) ? w_resp_data : r_hold[gi];
  end

  assign ack0      = w_ack[0];
  assign ack1      = w_ack[1];
  assign err0      = w_ack[0] & r_err_pend;
  assign err1      = w_ack[1] & r_err_pend;
  assign rdata0    = w_rdata[0];
  assign rdata1    = w_rdata[1];
  assign busy      = (r_state != S_IDLE);
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [3:0]  wmask0 = '0, wmask1 = '0;
  logic        ack0, ack1, err0, err1, busy, mem_en, mem_we;
  logic [31:0] rdata0, rdata1, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(32), .MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .wmask0(wmask0), .wmask1(wmask1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  // Synchronous memory with a backdoor port for preloading.
  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct { logic [31:0] rdata; logic err; } sb_t;
  sb_t         q0[$], q1[$];
  sb_t         mon_e;
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_hold [2];
  int          total = 0, bad = 0, cyc = 0;
  int          ack_port[$], ack_cyc[$];
  logic        prev_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Computes the expected response from the reference model and queues it.
  task automatic push_exp(input bit p, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    sb_t e;
    if (a[31:2] >= 30'd1024) begin
      e.rdata = '0; e.err = 1'b1; exp_hold[p] = '0;
    end else if (w) begin
      ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], d, m);
      e.rdata = exp_hold[p]; e.err = 1'b0;
    end else begin
      e.rdata = ref_mem[a[11:2]]; e.err = 1'b0; exp_hold[p] = e.rdata;
    end
    if (p) q1.push_back(e); else q0.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every ack.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_en) check_val("en_gap", 32'(prev_en), 32'd0);
      if (ack0 | ack1) check_val("ack_excl", 32'(ack0 & ack1), 32'd0);
      if (ack0) begin
        $display("txn cyc=%0d port0 rdata=%h err=%b", cyc, rdata0, err0);
        if (q0.size() == 0) check_val("ack0_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = q0.pop_front();
          check_val("rdata0", rdata0, mon_e.rdata);
          check_val("err0", 32'(err0), 32'(mon_e.err));
        end
        ack_port.push_back(0); ack_cyc.push_back(cyc);
      end
      if (ack1) begin
        $display("txn cyc=%0d port1 rdata=%h err=%b", cyc, rdata1, err1);
        if (q1.size() == 0) check_val("ack1_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = q1.pop_front();
          check_val("rdata1", rdata1, mon_e.rdata);
          check_val("err1", 32'(err1), 32'(mon_e.err));
        end
        ack_port.push_back(1); ack_cyc.push_back(cyc);
      end
    end
    prev_en = mem_en;
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    exp_hold[0] = '0; exp_hold[1] = '0;
  endtask

  task automatic preload(input logic [9:0] wa, input logic [31:0] v);
    @(posedge clk); #1 bd_we = 1'b1; bd_addr = wa; bd_data = v;
    @(posedge clk); #1 bd_we = 1'b0;
    ref_mem[wa] = v;
  endtask

  // One complete request on port p. en1/ma report mem_en/mem_addr one
  // cycle after the request is sampled; lat counts cycles to the ack.
  task automatic access(input bit p, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input bit chg,
                        output logic en1, output logic [9:0] ma, output int lat);
    push_exp(p, w, a, d, m);
    @(posedge clk); #1;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; wmask1 = m; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; wmask0 = m; end
    @(posedge clk); #1;
    if (chg) begin
      if (p) addr1 = a ^ 32'h0000_0FFC; else addr0 = a ^ 32'h0000_0FFC;
    end
    @(negedge clk);
    en1 = mem_en; ma = mem_addr; lat = 1;
    while (!(p ? ack1 : ack0) && lat < 40) begin
      @(negedge clk); lat++;
    end
    if (!(p ? ack1 : ack0)) check_val("ack_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  logic       t_en, c0_en, c1_en;
  logic [9:0] t_ma, c0_ma, c1_ma;
  int         t_lat, c0_lat, c1_lat, n;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_hold[0] = '0; exp_hold[1] = '0;
    do_reset();
    @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ack", 32'({ack1, ack0}), 32'd0);
    check_val("rst_err", 32'({err1, err0}), 32'd0);
    check_val("rst_mem_en", 32'({mem_we, mem_en}), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    check_val("rst_rdata0", rdata0, 32'd0);
    check_val("rst_rdata1", rdata1, 32'd0);

    preload(10'h010, 32'hDEADBEEF);
    preload(10'h002, 32'hAAAAAAAA);
    preload(10'h005, 32'h55555555);
    for (int i = 0; i < 8; i++) preload(10'h020 + 10'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101);

    // Core read alone.
    access(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, t_en, t_ma, t_lat);
    check_val("rd_en_at1", 32'(t_en), 32'd1);
    check_val("rd_addr", 32'(t_ma), 32'h10);
    check_val("rd_lat", 32'(t_lat), 32'd2);
    @(negedge clk); @(negedge clk);
    check_val("rd_hold0", rdata0, 32'hDEADBEEF);

    // Masked write from the loader, then read back.
    access(1'b1, 1'b1, 32'h8, 32'h11223344, 4'b0101, 1'b0, t_en, t_ma, t_lat);
    check_val("wr_en_at1", 32'(t_en), 32'd1);
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, t_en, t_ma, t_lat);
    @(negedge clk);
    check_val("mw_rd", rdata1, 32'hAA22AA44);
    check_val("hold0_kept", rdata0, 32'hDEADBEEF);

    // Zero-mask write leaves memory untouched.
    access(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 1'b0, t_en, t_ma, t_lat);
    check_val("wm0_lat", 32'(t_lat), 32'd2);
    access(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, t_en, t_ma, t_lat);

    // Out-of-range read, then a normal one.
    access(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, t_en, t_ma, t_lat);
    check_val("oor_en", 32'(t_en), 32'd0);
    check_val("oor_lat", 32'(t_lat), 32'd2);
    @(negedge clk);
    check_val("oor_hold", rdata0, 32'd0);
    access(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, t_en, t_ma, t_lat);

    // Address changes after the grant are ignored.
    access(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b1, t_en, t_ma, t_lat);
    check_val("chg_addr", 32'(t_ma), 32'h5);

    // Reset while a port-1 read is in ISSUE; req1 stays high.
    push_exp(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    @(posedge clk); #1 req1 = 1'b1; we1 = 1'b0; addr1 = 32'h80;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_val("rst_issue_en", 32'(mem_en), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    exp_hold[0] = '0; exp_hold[1] = '0;
    @(negedge clk);
    check_val("rst_no_ack", 32'(ack1), 32'd0);
    check_val("rst_idle", 32'(busy), 32'd0);
    n = 1;
    while (!ack1 && n < 40) begin @(negedge clk); n++; end
    check_val("rst_restart_lat", 32'(n), 32'd3);
    @(posedge clk); #1 req1 = 1'b0;

    // Conflict right after reset: 4 reads per port, back to back.
    do_reset();
    ack_port.delete(); ack_cyc.delete();
    fork
      for (int i = 0; i < 4; i++)
        access(1'b0, 1'b0, 32'h80 + 32'(8 * i), 32'h0, 4'h0, 1'b0, c0_en, c0_ma, c0_lat);
      for (int j = 0; j < 4; j++)
        access(1'b1, 1'b0, 32'h84 + 32'(8 * j), 32'h0, 4'h0, 1'b0, c1_en, c1_ma, c1_lat);
    join
    check_val("conf_count", 32'(ack_port.size()), 32'd8);
    for (int i = 0; i < ack_port.size(); i++) check_val("conf_alt", 32'(ack_port[i]), 32'(i % 2));
    if (ack_cyc.size() >= 2) check_val("conf_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd2);
    else check_val("conf_gap", 32'd0, 32'd2);

    repeat (3) @(negedge clk);
    check_val("q0_left", 32'(q0.size()), 32'd0);
    check_val("q1_left", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
